imem_loader: RTL

UART boot loader that fills the instruction memory of the single-cycle RISC-V core before the core runs. It receives a framed byte stream on a serial pin, assembles little-endian 32-bit instruction words, and writes them into instruction memory at sequential word addresses. It holds the core in reset (`cpu_reset`) until a complete image is loaded. It is the writer side of the instruction-memory port that the datapath reads via `pc_out`.

---
 rtl/imem_loader.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// UART boot loader for the instruction memory of the single-cycle RISC-V core.
// A framed byte stream (0xA5, N[7:0], N[15:8], then N little-endian 32-bit
// words) arrives on rx. Each complete word is written to instruction memory at
// the next sequential word address. The core is held in reset until the
// whole image has been consumed.
//
// Ports:
//   clk         system clock, single domain
//   reset       synchronous, active-high reset
//   rx          UART serial input (idle high, 8N1, LSB first), asynchronous
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write (holds between writes)
//   imem_wdata  instruction word of the write (holds between writes)
//   cpu_reset   high until the image is fully loaded
//   load_done   high once the image is fully loaded
//   frame_err   sticky, set on any bad stop bit
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic                  frame_err
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0]       SYNC_BYTE = 8'hA5;

   // ---------------------------------------------------------------------------
   // RX synchronizer and edge history
   // ---------------------------------------------------------------------------
   logic rx_meta;
   logic rx_sync;
   logic rx_prev;

   // NOTE: sequential state is assigned with <= only, so every flop samples
   // the pre-edge value of every other flop regardless of statement order.
   // The chain resets low rather than to the idle level: a line still held low
   // when reset drops then cannot look like a start edge, and a frame is only
   // recognised after a genuine high-to-low transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b0;
         rx_sync <= 1'b0;
         rx_prev <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // ---------------------------------------------------------------------------
   // UART receiver
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   rx_state_t        rx_state, rx_state_d;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
   logic [2:0]       rx_bit, rx_bit_d;
   logic [7:0]       rx_shift, rx_shift_d;
   logic             byte_valid;
   logic             stop_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_state_d;
         rx_cnt   <= rx_cnt_d;
         rx_bit   <= rx_bit_d;
         rx_shift <= rx_shift_d;
      end
   end

   // NOTE: every signal written here gets its hold/idle value first, so no
   // branch can leave one unassigned and infer a latch.
   always_comb begin
      rx_state_d = rx_state;
      rx_cnt_d   = rx_cnt;
      rx_bit_d   = rx_bit;
      rx_shift_d = rx_shift;
      byte_valid = 1'b0;
      stop_err   = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // Mid-start-bit recheck; a line back high was only a glitch.
            if (rx_cnt == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == CNT_BIT) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync, rx_shift[7:1]};
               rx_bit_d   = rx_bit + 3'd1;
               if (rx_bit == 3'd7) begin
                  rx_state_d = RX_STOP;
               end
            end else begin
               rx_cnt_d = rx_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == CNT_BIT) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               byte_valid = rx_sync;
               stop_err   = !rx_sync;
            end else begin
               rx_cnt_d = rx_cnt + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Protocol FSM and write port
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      P_IDLE,
      P_LEN0,
      P_LEN1,
      P_DATA,
      P_FINISH,  // cycle carrying the last write; done follows one clock later
      P_DONE
   } p_state_t;

   p_state_t              p_state, p_state_d;
   logic [15:0]           len, len_d;
   logic [15:0]           word_idx, word_idx_d;
   logic [1:0]            byte_cnt, byte_cnt_d;
   logic [23:0]           asm_word, asm_word_d;
   logic                  imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_d;
   logic [31:0]           imem_wdata_d;
   logic                  frame_err_d;
   logic                  in_range;
   logic [15:0]           idx_inc;
   logic [15:0]           len_full;

   assign in_range = (word_idx >> ADDR_WIDTH) == 16'd0;
   assign idx_inc  = word_idx + 16'd1;
   assign len_full = {rx_shift, len[7:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         p_state    <= P_IDLE;
         len        <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         asm_word   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         frame_err  <= 1'b0;
      end else begin
         p_state    <= p_state_d;
         len        <= len_d;
         word_idx   <= word_idx_d;
         byte_cnt   <= byte_cnt_d;
         asm_word   <= asm_word_d;
         imem_we    <= imem_we_d;
         imem_addr  <= imem_addr_d;
         imem_wdata <= imem_wdata_d;
         frame_err  <= frame_err_d;
      end
   end

   always_comb begin
      p_state_d    = p_state;
      len_d        = len;
      word_idx_d   = word_idx;
      byte_cnt_d   = byte_cnt;
      asm_word_d   = asm_word;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr;
      imem_wdata_d = imem_wdata;
      frame_err_d  = frame_err | stop_err;
      unique case (p_state)
         P_IDLE: begin
            if (byte_valid && rx_shift == SYNC_BYTE) begin
               p_state_d = P_LEN0;
            end
         end
         P_LEN0: begin
            if (stop_err) begin
               p_state_d = P_IDLE;
            end else if (byte_valid) begin
               len_d     = {len[15:8], rx_shift};
               p_state_d = P_LEN1;
            end
         end
         P_LEN1: begin
            if (stop_err) begin
               p_state_d = P_IDLE;
            end else if (byte_valid) begin
               len_d = len_full;
               if (len_full == 16'd0) begin
                  p_state_d = P_DONE;
               end else begin
                  word_idx_d = '0;
                  byte_cnt_d = '0;
                  p_state_d  = P_DATA;
               end
            end
         end
         P_DATA: begin
            if (stop_err) begin
               p_state_d = P_IDLE;
            end else if (byte_valid) begin
               byte_cnt_d = byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) begin
                  // Words past the memory are consumed but never written, so
                  // the address cannot wrap onto already-loaded words.
                  if (in_range) begin
                     imem_we_d    = 1'b1;
                     imem_addr_d  = word_idx[ADDR_WIDTH-1:0];
                     imem_wdata_d = {rx_shift, asm_word};
                  end
                  word_idx_d = idx_inc;
                  if (idx_inc == len) begin
                     p_state_d = P_FINISH;
                  end
               end else begin
                  asm_word_d = {rx_shift, asm_word[23:8]};
               end
            end
         end
         P_FINISH: p_state_d = P_DONE;
         P_DONE:   p_state_d = P_DONE;
         default:  p_state_d = P_IDLE;
      endcase
   end

   assign load_done = (p_state == P_DONE);
   assign cpu_reset = !load_done;

endmodule
